ber_align_checker: RTL and testbench
====================================

BER_ALIGN_CHECKER -- requirements
Module: ber_align_checker

Interface
REQ-001 Parameter NCH, default 2: number of independent bit channels (I, Q, ...).
REQ-002 Parameter NDELAY, default 16: number of candidate reference delays (taps 0..NDELAY-1).
REQ-003 Parameter NB_DLY, default $clog2(NDELAY): width of one delay field.
REQ-004 Parameter NB_CNT, default 64: width of each bit counter and each error counter.
REQ-005 Parameter SETUP_LEN, default 511: valid bits per delay trial during search.
REQ-006 Parameter MAX_SETUP_ERR, default 0: maximum best-trial error count that still allows lock.
REQ-007 clock  in  1  single system clock; all logic on rising edge.
REQ-008 i_reset  in  1  asynchronous, active-low reset.
REQ-009 i_enable  in  1  high = block advances; low = full freeze.
REQ-010 i_valid  in  1  one-cycle bit strobe (baud-rate tick).
REQ-011 i_clear  in  1  synchronous restart of all channels.
REQ-012 i_rx  in  NCH  received (slicer) bits, bit c = channel c.
REQ-013 i_ref  in  NCH  local PRBS reference bits, bit c = channel c.
REQ-014 o_lock  out  NCH  channel c aligned and counting.
REQ-015 o_delay  out  NCH*NB_DLY  current trial delay (search) or locked delay; field c at [c*NB_DLY +: NB_DLY].
REQ-016 o_bit_count  out  NCH*NB_CNT  bits compared since lock; field c at [c*NB_CNT +: NB_CNT].
REQ-017 o_err_count  out  NCH*NB_CNT  errors since lock; same packing.
REQ-018 o_err_bit  out  NCH  registered XOR of rx and selected tap for the last accepted strobe.

Function
REQ-019 Accepted strobe = i_enable & i_valid & ~i_clear; nothing changes on any other cycle except via i_clear.
REQ-020 Per channel, reference history shift register of NDELAY-1 bits shifts in i_ref on each accepted strobe.
REQ-021 Tap 0 = current i_ref; tap d (d>=1) = i_ref value from d accepted strobes earlier.
REQ-022 Compare bit = i_rx[c] XOR tap(o_delay field c), evaluated on the accepted strobe.
REQ-023 Channels are fully independent: separate FSM, counters and delay per channel.
REQ-024 FSM states per channel: SEARCH, LOCK; reset and i_clear enter SEARCH with delay 0.
REQ-025 SEARCH: trial counter counts accepted strobes 0..SETUP_LEN-1; trial error accumulator adds compare bit.
REQ-026 On the last strobe of a trial, total trial errors (including that strobe) compared with best; strictly less updates best_err and best_dly (ties keep lower delay).
REQ-027 After the trial, delay increments, trial counter and accumulator clear.
REQ-028 After trial of delay NDELAY-1: if best_err <= MAX_SETUP_ERR, go to LOCK with delay = best_dly; else stay in SEARCH, delay 0, best_err = all ones.
REQ-029 best_err is saturating and wide enough for SETUP_LEN; initialised all ones at each search start.
REQ-030 LOCK: each accepted strobe increments bit count; compare bit 1 increments error count.
REQ-031 Both counters saturate at 2^NB_CNT-1; no wrap.
REQ-032 o_lock = 1 only in LOCK; o_bit_count/o_err_count hold 0 throughout SEARCH.
REQ-033 All outputs registered; effect of an accepted strobe is visible on the next clock edge (latency 1).
REQ-034 o_err_bit updates on every accepted strobe in either state; holds otherwise.
REQ-035 i_clear has priority over i_valid: strobe in the same cycle is dropped; counters 0, lock 0, delay 0, trial state cleared; shift register content retained.
REQ-036 i_enable low mid-trial: trial resumes exactly where it stopped when i_enable returns high.

Reset
REQ-037 Asynchronous assertion (i_reset=0): all registers cleared immediately, without waiting for a clock edge, including the shift register; best_err all ones; state SEARCH.
REQ-038 Reset values: o_lock=0, o_delay=0, o_bit_count=0, o_err_count=0, o_err_bit=0.
REQ-039 Release is synchronous to clock; the first accepted strobe after release starts trial 0 at delay 0.
REQ-040 Reset mid-search or mid-lock discards all progress; no partial state survives.

Verification
REQ-041 Assert i_reset=0 mid-lock, no clock edge -> all outputs 0 immediately.
REQ-042 NDELAY=16, SETUP_LEN=32, rx = ref delayed 5 strobes, both channels -> o_lock=1 one cycle after strobe 512, o_delay=5 per channel, o_err_count=0.
REQ-043 Locked channel 0, flip one rx bit -> o_err_bit[0] pulses 1 for one strobe, o_err_count ch0=1, ch1 unchanged.
REQ-044 rx random vs ref, MAX_SETUP_ERR=0 -> o_lock stays 0, o_delay wraps 15->0 and repeats.
REQ-045 ref and rx constant 1 -> every trial 0 errors, lock with o_delay=0 (tie rule).
REQ-046 NB_CNT=4, locked -> o_bit_count stops at 15; i_clear together with i_valid -> strobe dropped, counters 0, search restarts at delay 0.

Source files
------------

// File: rtl/ber_align_checker_if.sv
// ----------------------------------------------------------------------------
// ber_align_checker_if
//
// Purpose: bundles the strobe/data inputs and the status outputs of the
// bit-error-rate alignment checker so that the checker and its environment
// share one port object.
//
// Strobe semantics: there is no back-pressure. A bit strobe is accepted on a
// rising clock edge when i_enable & i_valid & ~i_clear. i_clear restarts the
// checker on the edge where it is high and wins over a coincident strobe.
//
// Signals:
//   i_enable     1            block advances when high, full freeze when low
//   i_valid      1            one-cycle bit strobe (baud-rate tick)
//   i_clear      1            synchronous restart of all channels
//   i_rx         NCH          received bits, bit c = channel c
//   i_ref        NCH          local PRBS reference bits, bit c = channel c
//   o_lock       NCH          channel c aligned and counting
//   o_delay      NCH*NB_DLY   trial or locked delay, field c at [c*NB_DLY +: NB_DLY]
//   o_bit_count  NCH*NB_CNT   bits compared since lock, field c at [c*NB_CNT +: NB_CNT]
//   o_err_count  NCH*NB_CNT   errors since lock, same packing
//   o_err_bit    NCH          registered compare bit of the last accepted strobe
//   o_dbg_state  NCH          per-channel FSM state (0 = SEARCH, 1 = LOCK)
//
// Modports: master drives the inputs (environment), slave is the checker.
// ----------------------------------------------------------------------------
interface ber_align_checker_if #(
    parameter int NCH    = 2,
    parameter int NB_DLY = 4,
    parameter int NB_CNT = 64
);
    logic                  i_enable;
    logic                  i_valid;
    logic                  i_clear;
    logic [NCH-1:0]        i_rx;
    logic [NCH-1:0]        i_ref;
    logic [NCH-1:0]        o_lock;
    logic [NCH*NB_DLY-1:0] o_delay;
    logic [NCH*NB_CNT-1:0] o_bit_count;
    logic [NCH*NB_CNT-1:0] o_err_count;
    logic [NCH-1:0]        o_err_bit;
    logic [NCH-1:0]        o_dbg_state;

    modport master (
        output i_enable, i_valid, i_clear, i_rx, i_ref,
        input  o_lock, o_delay, o_bit_count, o_err_count, o_err_bit, o_dbg_state
    );

    modport slave (
        input  i_enable, i_valid, i_clear, i_rx, i_ref,
        output o_lock, o_delay, o_bit_count, o_err_count, o_err_bit, o_dbg_state
    );
endinterface

// File: rtl/ber_align_checker.sv
// ----------------------------------------------------------------------------
// ber_align_checker
//
// Purpose: per-channel alignment of a received bit stream against a local
// PRBS reference, followed by bit/error counting once aligned.
//
// Each channel keeps a short history of reference bits. During SEARCH it
// tries every candidate delay for SETUP_LEN accepted strobes, remembers the
// delay with the fewest errors (lowest delay on ties) and, after the last
// candidate, locks onto it if its error count is small enough. In LOCK it
// counts compared bits and errors with saturating counters.
//
// Ports:
//   clock    system clock, all logic on the rising edge
//   i_reset  asynchronous active-low reset
//   bus      ber_align_checker_if.slave (strobe, data and status signals)
//
// Latency: every output is a register; an accepted strobe shows its effect
// on the clock edge that accepts it.
// ----------------------------------------------------------------------------
module ber_align_checker #(
    parameter int NCH           = 2,
    parameter int NDELAY        = 16,
    parameter int NB_DLY        = $clog2(NDELAY),
    parameter int NB_CNT        = 64,
    parameter int SETUP_LEN     = 511,
    parameter int MAX_SETUP_ERR = 0
) (
    input  logic                clock,
    input  logic                i_reset,
    ber_align_checker_if.slave  bus
);

    // Trial counters and error accumulators must hold values up to SETUP_LEN.
    localparam int NB_TRL = $clog2(SETUP_LEN + 1);

    localparam logic [NB_TRL-1:0] ERR_ALL_ONES = '1;
    localparam logic [NB_TRL-1:0] TRL_ONE      = NB_TRL'(1);
    localparam logic [NB_TRL-1:0] TRIAL_LAST   = NB_TRL'(SETUP_LEN - 1);
    localparam logic [NB_TRL-1:0] MAX_ERR      = NB_TRL'(MAX_SETUP_ERR);
    localparam logic [NB_DLY-1:0] DLY_LAST     = NB_DLY'(NDELAY - 1);
    localparam logic [NB_DLY-1:0] DLY_ONE      = NB_DLY'(1);
    localparam logic [NB_CNT-1:0] CNT_MAX      = '1;
    localparam logic [NB_CNT-1:0] CNT_ONE      = NB_CNT'(1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCK   = 1'b1
    } state_t;

    logic accept;
    assign accept = bus.i_enable & bus.i_valid & ~bus.i_clear;

    logic [NCH-1:0]        lock_w;
    logic [NCH-1:0]        dbg_w;
    logic [NCH-1:0]        ebit_w;
    logic [NCH*NB_DLY-1:0] dly_w;
    logic [NCH*NB_CNT-1:0] bits_w;
    logic [NCH*NB_CNT-1:0] errs_w;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t              state_q, state_d;
        logic [NDELAY-2:0]   hist_q, hist_d;       // bit k = ref from k+1 strobes ago
        logic [NB_DLY-1:0]   dly_q, dly_d;
        logic [NB_DLY-1:0]   best_dly_q, best_dly_d;
        logic [NB_TRL-1:0]   trial_q, trial_d;
        logic [NB_TRL-1:0]   acc_q, acc_d;
        logic [NB_TRL-1:0]   best_q, best_d;
        logic [NB_CNT-1:0]   bits_q, bits_d;
        logic [NB_CNT-1:0]   errs_q, errs_d;
        logic                ebit_q, ebit_d;

        logic [NDELAY-1:0]   taps;
        logic                cmp;
        logic [NB_TRL-1:0]   trial_err;
        logic                better;
        logic [NB_TRL-1:0]   best_new;
        logic [NB_DLY-1:0]   best_dly_new;

        // Tap 0 is the live reference bit, tap d the bit d strobes back.
        assign taps = {hist_q, bus.i_ref[c]};
        assign cmp  = bus.i_rx[c] ^ taps[dly_q];

        // Trial total includes the strobe currently being accepted. Only a
        // strictly smaller total replaces the best, so ties keep the lower
        // delay that was tried first.
        assign trial_err    = acc_q + {{(NB_TRL-1){1'b0}}, cmp};
        assign better       = (trial_err < best_q);
        assign best_new     = better ? trial_err : best_q;
        assign best_dly_new = better ? dly_q : best_dly_q;

        always_comb begin
            state_d    = state_q;
            hist_d     = hist_q;
            dly_d      = dly_q;
            best_dly_d = best_dly_q;
            trial_d    = trial_q;
            acc_d      = acc_q;
            best_d     = best_q;
            bits_d     = bits_q;
            errs_d     = errs_q;
            ebit_d     = ebit_q;

            if (bus.i_clear) begin
                // Restart the search; reference history and the last
                // compare bit are deliberately kept.
                state_d    = ST_SEARCH;
                dly_d      = '0;
                best_dly_d = '0;
                trial_d    = '0;
                acc_d      = '0;
                best_d     = ERR_ALL_ONES;
                bits_d     = '0;
                errs_d     = '0;
            end else if (accept) begin
                hist_d = taps[NDELAY-2:0];
                ebit_d = cmp;
                case (state_q)
                    ST_SEARCH: begin
                        if (trial_q == TRIAL_LAST) begin
                            trial_d = '0;
                            acc_d   = '0;
                            if (dly_q == DLY_LAST) begin
                                // Sweep complete: lock on the best delay or
                                // start a fresh sweep from delay 0.
                                if (best_new <= MAX_ERR) begin
                                    state_d = ST_LOCK;
                                    dly_d   = best_dly_new;
                                end else begin
                                    dly_d   = '0;
                                end
                                best_d     = ERR_ALL_ONES;
                                best_dly_d = '0;
                            end else begin
                                dly_d      = dly_q + DLY_ONE;
                                best_d     = best_new;
                                best_dly_d = best_dly_new;
                            end
                        end else begin
                            trial_d = trial_q + TRL_ONE;
                            acc_d   = trial_err;
                        end
                    end
                    ST_LOCK: begin
                        if (bits_q != CNT_MAX) begin
                            bits_d = bits_q + CNT_ONE;
                        end
                        if (cmp && (errs_q != CNT_MAX)) begin
                            errs_d = errs_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_SEARCH;
                    end
                endcase
            end
        end

        always_ff @(posedge clock or negedge i_reset) begin
            if (!i_reset) begin
                state_q    <= ST_SEARCH;
                hist_q     <= '0;
                dly_q      <= '0;
                best_dly_q <= '0;
                trial_q    <= '0;
                acc_q      <= '0;
                best_q     <= ERR_ALL_ONES;
                bits_q     <= '0;
                errs_q     <= '0;
                ebit_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                hist_q     <= hist_d;
                dly_q      <= dly_d;
                best_dly_q <= best_dly_d;
                trial_q    <= trial_d;
                acc_q      <= acc_d;
                best_q     <= best_d;
                bits_q     <= bits_d;
                errs_q     <= errs_d;
                ebit_q     <= ebit_d;
            end
        end

        assign lock_w[c]                  = (state_q == ST_LOCK);
        assign dbg_w[c]                   = state_q;
        assign ebit_w[c]                  = ebit_q;
        assign dly_w[c*NB_DLY +: NB_DLY]  = dly_q;
        assign bits_w[c*NB_CNT +: NB_CNT] = bits_q;
        assign errs_w[c*NB_CNT +: NB_CNT] = errs_q;
    end

    assign bus.o_lock      = lock_w;
    assign bus.o_dbg_state = dbg_w;
    assign bus.o_err_bit   = ebit_w;
    assign bus.o_delay     = dly_w;
    assign bus.o_bit_count = bits_w;
    assign bus.o_err_count = errs_w;

endmodule

// File: tb/tb_ber_align_checker.sv
// ----------------------------------------------------------------------------
// tb_ber_align_checker
//
// Random stimulus driven against ber_align_checker. A reference model keeps
// the full log of accepted reference words and, per channel, a table of
// error totals for every delay tried in the current sweep; the best delay is
// picked as the first minimum of that table. Expected outputs are queued
// per driven cycle and compared by an independent monitor.
// ----------------------------------------------------------------------------
module tb_ber_align_checker;

    localparam int NCH           = 2;
    localparam int NDELAY        = 16;
    localparam int NB_DLY        = 4;
    localparam int NB_CNT        = 4;
    localparam int SETUP_LEN     = 32;
    localparam int MAX_SETUP_ERR = 0;

    localparam int CMAX   = (1 << NB_CNT) - 1;
    localparam int OFF_L  = 0;
    localparam int OFF_D  = OFF_L + NCH;
    localparam int OFF_B  = OFF_D + NCH * NB_DLY;
    localparam int OFF_E  = OFF_B + NCH * NB_CNT;
    localparam int OFF_EB = OFF_E + NCH * NB_CNT;
    localparam int W      = OFF_EB + NCH;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic i_reset = 1'b0;
    always #5 clock = ~clock;

    ber_align_checker_if #(.NCH(NCH), .NB_DLY(NB_DLY), .NB_CNT(NB_CNT)) bus ();

    ber_align_checker #(
        .NCH(NCH), .NDELAY(NDELAY), .NB_DLY(NB_DLY), .NB_CNT(NB_CNT),
        .SETUP_LEN(SETUP_LEN), .MAX_SETUP_ERR(MAX_SETUP_ERR)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int             m_lock[NCH];
    int             m_dly[NCH];
    int             m_pos[NCH];
    int             m_bits[NCH];
    int             m_errs[NCH];
    int             m_tab[NCH][NDELAY];
    logic [NCH-1:0] m_ebit;
    logic [NCH-1:0] ref_log[$];

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_lock[c] = 0; m_dly[c] = 0; m_pos[c] = 0; m_bits[c] = 0; m_errs[c] = 0;
            for (int d = 0; d < NDELAY; d++) m_tab[c][d] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        m_ebit = '0;
        ref_log.delete();
    endtask

    function automatic logic [NCH-1:0] past_ref(input int d);
        if (d == 0) return '0;
        if (ref_log.size() >= d) return ref_log[ref_log.size() - d];
        return '0;
    endfunction

    task automatic model_strobe(input logic [NCH-1:0] rx, input logic [NCH-1:0] rf);
        logic [NCH-1:0] old;
        for (int c = 0; c < NCH; c++) begin
            int   best;
            int   bidx;
            logic tap;
            logic e;
            old = past_ref(m_dly[c]);
            tap = (m_dly[c] == 0) ? rf[c] : old[c];
            e   = rx[c] ^ tap;
            m_ebit[c] = e;
            if (m_lock[c] == 0) begin
                m_tab[c][m_dly[c]] += int'(e);
                m_pos[c]++;
                if (m_pos[c] == SETUP_LEN) begin
                    m_pos[c] = 0;
                    if (m_dly[c] == NDELAY - 1) begin
                        best = m_tab[c][0];
                        bidx = 0;
                        for (int d = 1; d < NDELAY; d++) begin
                            if (m_tab[c][d] < best) begin
                                best = m_tab[c][d];
                                bidx = d;
                            end
                        end
                        if (best <= MAX_SETUP_ERR) begin
                            m_lock[c] = 1;
                            m_dly[c]  = bidx;
                        end else begin
                            m_dly[c] = 0;
                        end
                        for (int d = 0; d < NDELAY; d++) m_tab[c][d] = 0;
                    end else begin
                        m_dly[c]++;
                    end
                end
            end else begin
                if (m_bits[c] < CMAX) m_bits[c]++;
                if (e && m_errs[c] < CMAX) m_errs[c]++;
            end
        end
        ref_log.push_back(rf);
    endtask

    function automatic logic [W-1:0] model_pack();
        logic [NCH-1:0]        l;
        logic [NCH*NB_DLY-1:0] d;
        logic [NCH*NB_CNT-1:0] b;
        logic [NCH*NB_CNT-1:0] e;
        for (int c = 0; c < NCH; c++) begin
            l[c]                  = (m_lock[c] != 0);
            d[c*NB_DLY +: NB_DLY] = NB_DLY'(m_dly[c]);
            b[c*NB_CNT +: NB_CNT] = NB_CNT'(m_bits[c]);
            e[c*NB_CNT +: NB_CNT] = NB_CNT'(m_errs[c]);
        end
        return {m_ebit, e, b, d, l};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic v, input logic clr,
                         input logic [NCH-1:0] rx, input logic [NCH-1:0] rf);
        @(negedge clock);
        bus.i_enable = en;
        bus.i_valid  = v;
        bus.i_clear  = clr;
        bus.i_rx     = rx;
        bus.i_ref    = rf;
        if (clr) model_clear();
        else if (en && v) model_strobe(rx, rf);
        exp_q.push_back(model_pack());
    endtask

    // Accepted strobe, sometimes preceded by an idle or frozen cycle.
    task automatic strobe(input logic [NCH-1:0] rx, input logic [NCH-1:0] rf);
        if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0)
                drive(1'b1, 1'b0, 1'b0, NCH'($urandom), NCH'($urandom));
            else
                drive(1'b0, 1'b1, 1'b0, NCH'($urandom), NCH'($urandom));
        end
        drive(1'b1, 1'b1, 1'b0, rx, rf);
    endtask

    // Park the inputs idle and let the monitor drain the queue.
    task automatic settle();
        int n;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clock);
            #3;
            n++;
        end
        if (exp_q.size() != 0) check("queue_drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;

    always @(posedge clock) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {bus.o_err_bit, bus.o_err_count, bus.o_bit_count, bus.o_delay, bus.o_lock};
            check("o_lock",      64'(mon_act[OFF_L +: NCH]),         64'(mon_exp[OFF_L +: NCH]));
            check("o_delay",     64'(mon_act[OFF_D +: NCH*NB_DLY]),  64'(mon_exp[OFF_D +: NCH*NB_DLY]));
            check("o_bit_count", 64'(mon_act[OFF_B +: NCH*NB_CNT]),  64'(mon_exp[OFF_B +: NCH*NB_CNT]));
            check("o_err_count", 64'(mon_act[OFF_E +: NCH*NB_CNT]),  64'(mon_exp[OFF_E +: NCH*NB_CNT]));
            check("o_err_bit",   64'(mon_act[OFF_EB +: NCH]),        64'(mon_exp[OFF_EB +: NCH]));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_lock"},  64'(bus.o_lock),      64'd0);
        check({tag, "_delay"}, 64'(bus.o_delay),     64'd0);
        check({tag, "_bits"},  64'(bus.o_bit_count), 64'd0);
        check({tag, "_errs"},  64'(bus.o_err_count), 64'd0);
        check({tag, "_ebit"},  64'(bus.o_err_bit),   64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [NCH-1:0] rf;
        bus.i_enable = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_clear  = 1'b0;
        bus.i_rx     = '0;
        bus.i_ref    = '0;
        model_reset();

        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        i_reset = 1'b1;

        // Alignment: rx is the reference delayed by 5 strobes on both channels.
        for (int n = 0; n < NDELAY * SETUP_LEN; n++) begin
            rf = NCH'($urandom);
            strobe(past_ref(5), rf);
        end
        settle();
        check("align_lock",  64'(bus.o_lock),      64'h3);
        check("align_delay", 64'(bus.o_delay),     64'h55);
        check("align_errs",  64'(bus.o_err_count), 64'd0);

        // Keep counting until the 4-bit bit counter saturates.
        for (int n = 0; n < 20; n++) begin
            rf = NCH'($urandom);
            strobe(past_ref(5), rf);
        end
        settle();
        check("bits_saturate", 64'(bus.o_bit_count), 64'hff);

        // Single error on channel 0 only.
        rf = NCH'($urandom);
        strobe(past_ref(5) ^ 2'b01, rf);
        settle();
        check("flip_ebit", 64'(bus.o_err_bit),   64'h1);
        check("flip_errs", 64'(bus.o_err_count), 64'h01);
        rf = NCH'($urandom);
        strobe(past_ref(5), rf);
        settle();
        check("flip_ebit_end", 64'(bus.o_err_bit),   64'h0);
        check("flip_errs_end", 64'(bus.o_err_count), 64'h01);

        // Clear coincident with a strobe: the strobe is dropped.
        drive(1'b1, 1'b1, 1'b1, NCH'($urandom), NCH'($urandom));
        settle();
        check("clear_lock",  64'(bus.o_lock),      64'd0);
        check("clear_delay", 64'(bus.o_delay),     64'd0);
        check("clear_bits",  64'(bus.o_bit_count), 64'd0);
        check("clear_errs",  64'(bus.o_err_count), 64'd0);

        // Uncorrelated rx: never locks, delay sweeps 0..15 twice.
        for (int n = 0; n < 2 * NDELAY * SETUP_LEN; n++) begin
            strobe(NCH'($urandom), NCH'($urandom));
        end
        settle();
        check("random_nolock", 64'(bus.o_lock), 64'd0);

        // Constant ones: every trial is clean, tie rule picks delay 0.
        drive(1'b1, 1'b0, 1'b1, '0, '0);
        for (int n = 0; n < NDELAY * SETUP_LEN; n++) begin
            strobe(2'b11, 2'b11);
        end
        settle();
        check("ones_lock",  64'(bus.o_lock),  64'h3);
        check("ones_delay", 64'(bus.o_delay), 64'h00);

        // Locked at delay 0, count a little, then reset asynchronously.
        for (int n = 0; n < 10; n++) begin
            rf = NCH'($urandom);
            strobe(rf ^ NCH'($urandom_range(0, 1)), rf);
        end
        settle();
        i_reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        i_reset = 1'b1;

        // Fresh search from trial 0 after release.
        for (int n = 0; n < 3 * SETUP_LEN; n++) begin
            rf = NCH'($urandom);
            strobe(past_ref(3), rf);
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
